// File: rtl/video_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : video_mode_ctrl
//  Description : Shadowed video-mode / scroll / interrupt-position registers
//                with raster-safe commit scheduling for the raster generator.
//  Revision    : 1.0  initial release
// ============================================================================
module video_mode_ctrl #(
   parameter logic [7:0] RST_HINT = 8'd1,
   parameter logic [8:0] RST_VINT = 9'd0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_en,
   input  logic [2:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic [3:0] rd_addr,
   output logic [7:0] rd_data,
   input  logic       frame_start_s,
   input  logic       line_start_s,
   output logic [8:0] hpix_beg,
   output logic [8:0] hpix_end,
   output logic [8:0] vpix_beg,
   output logic [8:0] vpix_end,
   output logic [4:0] go_offs,
   output logic [1:0] x_offs,
   output logic [7:0] cstart,
   output logic [8:0] rstart,
   output logic [7:0] hint_beg,
   output logic [8:0] vint_beg,
   output logic [1:0] vmode,
   output logic       nogfx,
   output logic       cfg_60hz,
   output logic       y_offs_wr
);

   // Register map
   localparam logic [2:0] C_A_VCONF = 3'd0;
   localparam logic [2:0] C_A_GXL   = 3'd1;
   localparam logic [2:0] C_A_GXH   = 3'd2;
   localparam logic [2:0] C_A_GYL   = 3'd3;
   localparam logic [2:0] C_A_GYH   = 3'd4;
   localparam logic [2:0] C_A_HINT  = 3'd5;
   localparam logic [2:0] C_A_VINTL = 3'd6;
   localparam logic [2:0] C_A_VINTH = 3'd7;

   // Pending-flag bit positions
   localparam int C_PM = 0;
   localparam int C_PX = 1;
   localparam int C_PY = 2;
   localparam int C_PI = 3;

   // Shadow registers (CPU side); VCONF bits 3:2 are unused and held at 0
   logic [7:0] vconf_q;
   logic [8:0] gx_q;
   logic [8:0] gy_q;
   logic [7:0] hint_q;
   logic [8:0] vint_q;
   logic [3:0] pend_q, pend_d;

   // Committed (raster side) registers
   logic [8:0] hpix_beg_q, hpix_end_q, vpix_beg_q, vpix_end_q;
   logic [4:0] go_offs_q;
   logic [1:0] x_offs_q;
   logic [7:0] cstart_q;
   logic [8:0] rstart_q;
   logic [7:0] hint_beg_q;
   logic [8:0] vint_beg_q;
   logic [1:0] vmode_q;
   logic       nogfx_q, cfg_60hz_q, y_offs_wr_q;

   // Table-lookup results for the current shadow VCONF
   logic [8:0] hpix_beg_d, hpix_end_d, vpix_beg_d, vpix_end_d;
   logic [4:0] go_offs_d;

   logic wr_m, wr_x, wr_y, wr_i;
   logic commit_m, commit_x, commit_y, commit_i;

   // A write to a group in the same cycle as its strobe blocks the commit,
   // so the freshly written shadow value is carried to the next strobe.
   assign wr_m = wr_en && (wr_addr == C_A_VCONF);
   assign wr_x = wr_en && ((wr_addr == C_A_GXL) || (wr_addr == C_A_GXH));
   assign wr_y = wr_en && ((wr_addr == C_A_GYL) || (wr_addr == C_A_GYH));
   assign wr_i = wr_en && ((wr_addr == C_A_HINT) || (wr_addr == C_A_VINTL) ||
                           (wr_addr == C_A_VINTH));

   assign commit_m = frame_start_s && pend_q[C_PM] && !wr_m;
   assign commit_x = line_start_s  && pend_q[C_PX] && !wr_x;
   assign commit_y = line_start_s  && pend_q[C_PY] && !wr_y;
   assign commit_i = frame_start_s && pend_q[C_PI] && !wr_i;

   // Pending flags: set by a write, cleared by a commit
   always_comb begin
      pend_d        = pend_q;
      pend_d[C_PM]  = wr_m | (pend_q[C_PM] & ~commit_m);
      pend_d[C_PX]  = wr_x | (pend_q[C_PX] & ~commit_x);
      pend_d[C_PY]  = wr_y | (pend_q[C_PY] & ~commit_y);
      pend_d[C_PI]  = wr_i | (pend_q[C_PI] & ~commit_i);
   end

   // Pixel window and fetch lead lookup from the shadow mode register
   always_comb begin
      hpix_beg_d = 9'd140;
      hpix_end_d = 9'd396;
      vpix_beg_d = 9'd80;
      vpix_end_d = 9'd272;
      go_offs_d  = 5'd18;
      case (vconf_q[7:6])
         2'd0: begin
            hpix_beg_d = 9'd140; hpix_end_d = 9'd396;
            vpix_beg_d = 9'd80;  vpix_end_d = 9'd272;
         end
         2'd1: begin
            hpix_beg_d = 9'd108; hpix_end_d = 9'd428;
            vpix_beg_d = 9'd76;  vpix_end_d = 9'd276;
         end
         2'd2: begin
            hpix_beg_d = 9'd108; hpix_end_d = 9'd428;
            vpix_beg_d = 9'd56;  vpix_end_d = 9'd296;
         end
         default: begin
            hpix_beg_d = 9'd88;  hpix_end_d = 9'd448;
            vpix_beg_d = 9'd32;  vpix_end_d = 9'd320;
         end
      endcase
      case (vconf_q[1:0])
         2'd0:    go_offs_d = 5'd18;
         2'd1:    go_offs_d = 5'd6;
         2'd2:    go_offs_d = 5'd10;
         default: go_offs_d = 5'd0;
      endcase
   end

   // Shadow registers and pending flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vconf_q <= 8'd0;
         gx_q    <= 9'd0;
         gy_q    <= 9'd0;
         hint_q  <= RST_HINT;
         vint_q  <= RST_VINT;
         pend_q  <= 4'd0;
      end else begin
         pend_q <= pend_d;
         if (wr_en) begin
            case (wr_addr)
               C_A_VCONF: vconf_q     <= wr_data & 8'hF3;
               C_A_GXL:   gx_q[7:0]   <= wr_data;
               C_A_GXH:   gx_q[8]     <= wr_data[0];
               C_A_GYL:   gy_q[7:0]   <= wr_data;
               C_A_GYH:   gy_q[8]     <= wr_data[0];
               C_A_HINT:  hint_q      <= wr_data;
               C_A_VINTL: vint_q[7:0] <= wr_data;
               default:   vint_q[8]   <= wr_data[0];
            endcase
         end
      end
   end

   // Committed outputs: each group loads from its shadow on its commit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hpix_beg_q  <= 9'd140;
         hpix_end_q  <= 9'd396;
         vpix_beg_q  <= 9'd80;
         vpix_end_q  <= 9'd272;
         go_offs_q   <= 5'd18;
         vmode_q     <= 2'd0;
         nogfx_q     <= 1'b0;
         cfg_60hz_q  <= 1'b0;
         x_offs_q    <= 2'd0;
         cstart_q    <= 8'd0;
         rstart_q    <= 9'd0;
         hint_beg_q  <= RST_HINT;
         vint_beg_q  <= RST_VINT;
         y_offs_wr_q <= 1'b0;
      end else begin
         y_offs_wr_q <= commit_y;
         if (commit_m) begin
            hpix_beg_q <= hpix_beg_d;
            hpix_end_q <= hpix_end_d;
            vpix_beg_q <= vpix_beg_d;
            vpix_end_q <= vpix_end_d;
            go_offs_q  <= go_offs_d;
            vmode_q    <= vconf_q[1:0];
            nogfx_q    <= vconf_q[5];
            cfg_60hz_q <= vconf_q[4];
         end
         if (commit_x) begin
            x_offs_q <= gx_q[1:0];
            cstart_q <= gx_q[8:1];
         end
         if (commit_y) begin
            rstart_q <= gy_q;
         end
         if (commit_i) begin
            hint_beg_q <= hint_q;
            vint_beg_q <= vint_q;
         end
      end
   end

   // Combinational readback of shadows and pending mask
   always_comb begin
      rd_data = 8'd0;
      case (rd_addr)
         4'd0:    rd_data = vconf_q;
         4'd1:    rd_data = gx_q[7:0];
         4'd2:    rd_data = {7'd0, gx_q[8]};
         4'd3:    rd_data = gy_q[7:0];
         4'd4:    rd_data = {7'd0, gy_q[8]};
         4'd5:    rd_data = hint_q;
         4'd6:    rd_data = vint_q[7:0];
         4'd7:    rd_data = {7'd0, vint_q[8]};
         4'd8:    rd_data = {4'd0, pend_q};
         default: rd_data = 8'd0;
      endcase
   end

   assign hpix_beg  = hpix_beg_q;
   assign hpix_end  = hpix_end_q;
   assign vpix_beg  = vpix_beg_q;
   assign vpix_end  = vpix_end_q;
   assign go_offs   = go_offs_q;
   assign x_offs    = x_offs_q;
   assign cstart    = cstart_q;
   assign rstart    = rstart_q;
   assign hint_beg  = hint_beg_q;
   assign vint_beg  = vint_beg_q;
   assign vmode     = vmode_q;
   assign nogfx     = nogfx_q;
   assign cfg_60hz  = cfg_60hz_q;
   assign y_offs_wr = y_offs_wr_q;

endmodule
`default_nettype wire

// File: tb/tb_video_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_mode_ctrl
//  Description : Directed self-checking bench for video_mode_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_video_mode_ctrl;

   logic       clk;
   logic       rst_n;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [7:0] wr_data;
   logic [3:0] rd_addr;
   logic [7:0] rd_data;
   logic       frame_start_s;
   logic       line_start_s;
   logic [8:0] hpix_beg, hpix_end, vpix_beg, vpix_end;
   logic [4:0] go_offs;
   logic [1:0] x_offs;
   logic [7:0] cstart;
   logic [8:0] rstart;
   logic [7:0] hint_beg;
   logic [8:0] vint_beg;
   logic [1:0] vmode;
   logic       nogfx, cfg_60hz, y_offs_wr;

   int errors = 0;
   int checks = 0;

   video_mode_ctrl #(.RST_HINT(8'd1), .RST_VINT(9'd0)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .frame_start_s(frame_start_s), .line_start_s(line_start_s),
      .hpix_beg(hpix_beg), .hpix_end(hpix_end),
      .vpix_beg(vpix_beg), .vpix_end(vpix_end),
      .go_offs(go_offs), .x_offs(x_offs), .cstart(cstart), .rstart(rstart),
      .hint_beg(hint_beg), .vint_beg(vint_beg), .vmode(vmode),
      .nogfx(nogfx), .cfg_60hz(cfg_60hz), .y_offs_wr(y_offs_wr)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stimulus primitives: all drive at posedge+1 and return at posedge+1
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      cyc();
      wr_en = 1'b0;
   endtask

   task automatic strobe(input logic f, input logic l);
      frame_start_s = f; line_start_s = l;
      cyc();
      frame_start_s = 1'b0; line_start_s = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'd0;
      rd_addr = 4'd8; frame_start_s = 1'b0; line_start_s = 1'b0;
      repeat (3) cyc();
      rst_n = 1'b1;
      cyc();
      checks++;
      if ({hpix_beg, hpix_end, vpix_beg, vpix_end} !== {9'd140, 9'd396, 9'd80, 9'd272}) begin
         errors++;
         $display("FAIL reset_window: got %0d/%0d %0d/%0d want 140/396 80/272",
                  hpix_beg, hpix_end, vpix_beg, vpix_end);
      end
      checks++;
      if ({go_offs, x_offs, cstart, rstart} !== {5'd18, 2'd0, 8'd0, 9'd0}) begin
         errors++;
         $display("FAIL reset_fetch: got go=%0d x=%0d c=%0d r=%0d want 18 0 0 0",
                  go_offs, x_offs, cstart, rstart);
      end
      checks++;
      if ({hint_beg, vint_beg, vmode, nogfx, cfg_60hz, y_offs_wr} !== {8'd1, 9'd0, 2'd0, 3'b000}) begin
         errors++;
         $display("FAIL reset_misc: got hint=%0d vint=%0d vm=%0d ng=%b 60=%b y=%b want 1 0 0 0 0 0",
                  hint_beg, vint_beg, vmode, nogfx, cfg_60hz, y_offs_wr);
      end
      checks++;
      if (rd_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_pend: got %h want 00", rd_data);
      end
   endtask

   task automatic test_mode();
      wr(3'd0, 8'hC1);
      rd_addr = 4'd8; #1;
      checks++;
      if (rd_data !== 8'h01 || hpix_beg !== 9'd140) begin
         errors++;
         $display("FAIL mode_pending: got pend=%h hb=%0d want 01 140", rd_data, hpix_beg);
      end
      strobe(1'b1, 1'b0);
      checks++;
      if ({hpix_beg, hpix_end, vpix_beg, vpix_end, go_offs, vmode} !==
          {9'd88, 9'd448, 9'd32, 9'd320, 5'd6, 2'd1}) begin
         errors++;
         $display("FAIL mode_c1: got %0d/%0d %0d/%0d go=%0d vm=%0d want 88/448 32/320 6 1",
                  hpix_beg, hpix_end, vpix_beg, vpix_end, go_offs, vmode);
      end
      checks++;
      if (rd_data !== 8'h00) begin
         errors++;
         $display("FAIL mode_pend_clr: got %h want 00", rd_data);
      end
      // rres1, nogfx, vmode 2; bits 3:2 are unused and must read back 0
      wr(3'd0, 8'h6E);
      rd_addr = 4'd0; #1;
      checks++;
      if (rd_data !== 8'h62) begin
         errors++;
         $display("FAIL mode_readback: got %h want 62", rd_data);
      end
      strobe(1'b1, 1'b0);
      checks++;
      if ({hpix_beg, hpix_end, vpix_beg, vpix_end, go_offs, nogfx, cfg_60hz} !==
          {9'd108, 9'd428, 9'd76, 9'd276, 5'd10, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL mode_6e: got %0d/%0d %0d/%0d go=%0d ng=%b 60=%b want 108/428 76/276 10 1 0",
                  hpix_beg, hpix_end, vpix_beg, vpix_end, go_offs, nogfx, cfg_60hz);
      end
   endtask

   task automatic test_gx();
      wr(3'd1, 8'h37);
      wr(3'd2, 8'h01);
      strobe(1'b1, 1'b0);
      rd_addr = 4'd8; #1;
      checks++;
      if (x_offs !== 2'd0 || cstart !== 8'd0 || rd_data !== 8'h02) begin
         errors++;
         $display("FAIL gx_frame_only: got x=%0d c=%h pend=%h want 0 00 02", x_offs, cstart, rd_data);
      end
      strobe(1'b0, 1'b1);
      checks++;
      if (x_offs !== 2'd3 || cstart !== 8'h9B) begin
         errors++;
         $display("FAIL gx_commit: got x=%0d c=%h want 3 9b", x_offs, cstart);
      end
      // Pair split across a strobe: low byte commits alone first
      wr(3'd1, 8'h04);
      strobe(1'b0, 1'b1);
      checks++;
      if (x_offs !== 2'd0 || cstart !== 8'h82) begin
         errors++;
         $display("FAIL gx_split_lo: got x=%0d c=%h want 0 82", x_offs, cstart);
      end
      wr(3'd2, 8'h00);
      strobe(1'b0, 1'b1);
      checks++;
      if (cstart !== 8'h02) begin
         errors++;
         $display("FAIL gx_split_hi: got c=%h want 02", cstart);
      end
   endtask

   task automatic test_gy();
      wr(3'd3, 8'h05);
      strobe(1'b0, 1'b1);
      checks++;
      if (rstart !== 9'd5 || y_offs_wr !== 1'b1) begin
         errors++;
         $display("FAIL gy_commit: got r=%0d y=%b want 5 1", rstart, y_offs_wr);
      end
      cyc();
      checks++;
      if (y_offs_wr !== 1'b0) begin
         errors++;
         $display("FAIL gy_pulse_width: got y=%b want 0", y_offs_wr);
      end
      strobe(1'b0, 1'b1);
      checks++;
      if (y_offs_wr !== 1'b0 || rstart !== 9'd5) begin
         errors++;
         $display("FAIL gy_idle_strobe: got y=%b r=%0d want 0 5", y_offs_wr, rstart);
      end
   endtask

   task automatic test_coincident();
      wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h80;
      strobe(1'b1, 1'b0);
      wr_en = 1'b0;
      rd_addr = 4'd8; #1;
      checks++;
      if (hpix_beg !== 9'd108 || vpix_beg !== 9'd76 || go_offs !== 5'd10 || rd_data !== 8'h01) begin
         errors++;
         $display("FAIL coinc_hold: got hb=%0d vb=%0d go=%0d pend=%h want 108 76 10 01",
                  hpix_beg, vpix_beg, go_offs, rd_data);
      end
      strobe(1'b1, 1'b0);
      checks++;
      if ({hpix_beg, hpix_end, vpix_beg, vpix_end, go_offs, nogfx} !==
          {9'd108, 9'd428, 9'd56, 9'd296, 5'd18, 1'b0} || rd_data !== 8'h00) begin
         errors++;
         $display("FAIL coinc_apply: got %0d/%0d %0d/%0d go=%0d ng=%b pend=%h want 108/428 56/296 18 0 00",
                  hpix_beg, hpix_end, vpix_beg, vpix_end, go_offs, nogfx, rd_data);
      end
   endtask

   task automatic test_int();
      wr(3'd5, 8'h20);
      wr(3'd6, 8'h10);
      strobe(1'b0, 1'b1);
      checks++;
      if (hint_beg !== 8'h01 || vint_beg !== 9'h000) begin
         errors++;
         $display("FAIL int_line_only: got %h/%h want 01/000", hint_beg, vint_beg);
      end
      strobe(1'b1, 1'b0);
      checks++;
      if (hint_beg !== 8'h20 || vint_beg !== 9'h010) begin
         errors++;
         $display("FAIL int_commit: got %h/%h want 20/010", hint_beg, vint_beg);
      end
      wr(3'd7, 8'hFF);
      rd_addr = 4'd7; #1;
      checks++;
      if (rd_data !== 8'h01) begin
         errors++;
         $display("FAIL vinth_readback: got %h want 01", rd_data);
      end
      strobe(1'b1, 1'b0);
      checks++;
      if (vint_beg !== 9'h110) begin
         errors++;
         $display("FAIL vint_high: got %h want 110", vint_beg);
      end
   endtask

   task automatic test_both_strobes();
      wr(3'd0, 8'h13);
      wr(3'd3, 8'h07);
      wr(3'd4, 8'h01);
      strobe(1'b1, 1'b1);
      checks++;
      if (hpix_beg !== 9'd140 || go_offs !== 5'd0 || cfg_60hz !== 1'b1 ||
          rstart !== 9'h107 || y_offs_wr !== 1'b1) begin
         errors++;
         $display("FAIL both_strobes: got hb=%0d go=%0d 60=%b r=%h y=%b want 140 0 1 107 1",
                  hpix_beg, go_offs, cfg_60hz, rstart, y_offs_wr);
      end
   endtask

   task automatic test_async_reset();
      wr(3'd0, 8'hC2);
      wr(3'd1, 8'h55);
      wr(3'd3, 8'h09);
      wr(3'd5, 8'h44);
      rd_addr = 4'd8; #1;
      checks++;
      if (rd_data !== 8'h0F) begin
         errors++;
         $display("FAIL all_pending: got %h want 0f", rd_data);
      end
      // Mid-cycle, well away from any clock edge
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (rd_data !== 8'h00 || hpix_beg !== 9'd140 || go_offs !== 5'd18 ||
          cstart !== 8'd2 - 8'd2 || rstart !== 9'd0 || hint_beg !== 8'd1 ||
          vint_beg !== 9'd0 || cfg_60hz !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got pend=%h hb=%0d go=%0d c=%h r=%h hint=%h vint=%h 60=%b",
                  rd_data, hpix_beg, go_offs, cstart, rstart, hint_beg, vint_beg, cfg_60hz);
      end
      rd_addr = 4'd5; #1;
      checks++;
      if (rd_data !== 8'h01) begin
         errors++;
         $display("FAIL async_shadow: got %h want 01", rd_data);
      end
      cyc();
      rst_n = 1'b1;
      cyc();
   endtask

   initial begin
      test_reset();
      test_mode();
      test_gx();
      test_gy();
      test_coincident();
      test_int();
      test_both_strobes();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/video_mode_ctrl.md
# video_mode_ctrl

Register front-end and update scheduler for the raster generator. It holds CPU-written video mode, scroll offset and interrupt position registers in shadow copies. It commits each register group to the raster/DRAM-fetch parameter outputs only at a safe raster point, either frame start or line start, so that no line or frame ever sees a half-updated window. It sits between the Z80 port decoder and the video sync/fetch logic.

## Interface
Parameters:
- `RST_HINT`, 8'd1: reset value of `hint_beg`.
- `RST_VINT`, 9'd0: reset value of `vint_beg`.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  one-cycle register write strobe.
- `wr_addr`  in  3  register select.
- `wr_data`  in  8  write data.
- `rd_addr`  in  4  readback select.
- `rd_data`  out  8  combinational readback.
- `frame_start_s`  in  1  one-cycle strobe, last line's line end.
- `line_start_s`  in  1  one-cycle strobe, every line end.
- `hpix_beg`, `hpix_end`  out  9  horizontal pixel window (7 MHz counts).
- `vpix_beg`, `vpix_end`  out  9  vertical pixel window (lines).
- `go_offs`  out  5  DRAM fetch lead.
- `x_offs`  out  2  sub-column X scroll.
- `cstart`  out  8  start column.
- `rstart`  out  9  start row.
- `hint_beg`  out  8  line interrupt position.
- `vint_beg`  out  9  line interrupt position.
- `vmode`  out  2  pixel mode.
- `nogfx`, `cfg_60hz`  out  1  mode controls.
- `y_offs_wr`  out  1  one-cycle Y re-latch pulse to sync block.

## Operation
Registers (`wr_addr`), all with shadow copies:
- 0 VCONF: [7:6] rres, [5] nogfx, [4] cfg_60hz, [1:0] vmode.
- 1 GXL: gx[7:0].
- 2 GXH: gx[8] from bit 0.
- 3 GYL: gy[7:0].
- 4 GYH: gy[8] from bit 0.
- 5 HINT: hint[7:0].
- 6 VINTL: vint[7:0].
- 7 VINTH: vint[8] from bit 0.

Commit groups. Each group has a pending flag, set by any write to one of its registers.
- Group M (reg 0), committed on `frame_start_s`.
- Group X (regs 1–2), committed on `line_start_s`.
- Group Y (regs 3–4), committed on `line_start_s`.
- Group I (regs 5–7), committed on `frame_start_s`.
- On commit, the group's outputs load from its shadow and its pending flag clears.

Derived outputs:
- rres sets the pixel window, in the order hpix_beg/hpix_end, vpix_beg/vpix_end:
  - rres 0 (256x192): 140/396, 80/272.
  - rres 1 (320x200): 108/428, 76/276.
  - rres 2 (320x240): 108/428, 56/296.
  - rres 3 (360x288): 88/448, 32/320.
  - The vertical window does not depend on cfg_60hz. In 60 Hz mode, rres 2 and rres 3 are truncated by the sync block; this is accepted behaviour.
- vmode sets go_offs: 0→18, 1→6, 2→10, 3→0.
- x_offs = gx[1:0] and cstart = gx[8:1].
- rstart = gy.
- hint_beg = hint and vint_beg = vint.

Readback:
- `rd_addr` 0–7 returns the shadow value, with unused bits read as 0.
- `rd_addr` 8 returns {4'b0, pendI, pendY, pendX, pendM}.
- Other addresses return 0.

Boundary rules:
- Write in the same cycle as a commit strobe for the same group: the write wins. The shadow takes the new value, the outputs keep the old value, and pending stays set, so the value commits at the next strobe.
- `frame_start_s` and `line_start_s` together: all four groups commit in that cycle.
- 16-bit pair written across a strobe (low byte before the strobe, high byte after): the low byte alone commits, then the pair commits at the next strobe. Software writes the pair within one line; no lock is implemented.
- Strobes with no pending flag leave the outputs unchanged.
- Reset mid-operation: all shadows, outputs and pending flags return to their reset values immediately.

## Timing
- All outputs except `rd_data` are registered.
- A commit strobe in cycle N makes the new values visible after edge N+1.
- `y_offs_wr` is high for exactly cycle N+1 after a group Y commit. `rstart` is already valid in that cycle, so the sync block re-latches the row at the following line start.
- Reset values:
  - hpix 140/396, vpix 80/272.
  - go_offs 18, x_offs 0, cstart 0, rstart 0.
  - hint_beg `RST_HINT`, vint_beg `RST_VINT`.
  - vmode 0, nogfx 0, cfg_60hz 0.
  - y_offs_wr 0, all pending flags 0.
- Arithmetic:
  - cstart truncates gx bit 0 by construction.
  - No other computation; all derived values come from table lookup.

## Test plan
- Reset, then VCONF=8'hC1 and `frame_start_s` → one cycle later hpix 88/448, vpix 32/320, go_offs 6; rd 8 reads 0.
- GXL=8'h37, GXH=1, then `line_start_s` → x_offs 3, cstart 8'h9B; no change on `frame_start_s` alone before that.
- GYL=8'h05 then `line_start_s` → rstart 5, `y_offs_wr` high for exactly one cycle, 1 cycle after the strobe; a second `line_start_s` with no write gives no pulse.
- VCONF write coincident with `frame_start_s` → outputs unchanged, rd 8 = 1; next `frame_start_s` applies the value and rd 8 = 0.
- HINT=8'h20, VINTL=8'h10, then `line_start_s` only → hint/vint unchanged; then `frame_start_s` → 8'h20 / 9'h010.
- Assert `rst_n` low with all groups pending → pending mask 0 and outputs at reset values immediately, without waiting for a clock edge.
